// File: rtl/fifo_flow_monitor.sv
// Occupancy tracker for a bank of FIFOs: counts push/pop strobes, applies
// programmable hysteresis thresholds and raises pause/cont/error_full/empty.

module fifo_flow_lane #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [CNT_W-1:0] hi,
  input  logic [CNT_W-1:0] lo,
  output logic [CNT_W-1:0] count,
  output logic             pause,
  output logic             cont,
  output logic             err,
  output logic             empty
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic             paused;
  logic [CNT_W-1:0] n;

  // Pop of an empty FIFO is dropped; push at full only sticks when paired with a pop.
  always_comb begin
    n = count;
    if (push && !pop && count != DEPTH_C)   n = count + CNT_W'(1);
    else if (pop && !push && count != '0)   n = count - CNT_W'(1);
    else if (push && pop && count == '0)    n = CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      paused <= 1'b0;
      pause  <= 1'b0;
      cont   <= 1'b0;
      err    <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= n;
      empty <= (n == '0);
      pause <= 1'b0;
      cont  <= 1'b0;
      if (push && !pop && count == DEPTH_C) err <= 1'b1;
      if (!paused && n >= hi) begin
        paused <= 1'b1;
        pause  <= 1'b1;
      end else if (paused && n <= lo) begin
        paused <= 1'b0;
        cont   <= 1'b1;
      end
    end
  end
endmodule

module fifo_flow_monitor #(
  parameter int NUM_FIFOS = 4,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int DEF_HIGH  = 6,
  parameter int DEF_LOW   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic [CNT_W-1:0]           umbral_hi,
  input  logic [CNT_W-1:0]           umbral_lo,
  input  logic [NUM_FIFOS-1:0]       push,
  input  logic [NUM_FIFOS-1:0]       pop,
  output logic [NUM_FIFOS-1:0]       pause,
  output logic [NUM_FIFOS-1:0]       cont,
  output logic [NUM_FIFOS-1:0]       error_full,
  output logic [NUM_FIFOS-1:0]       empty,
  output logic                       all_empty,
  output logic [NUM_FIFOS*CNT_W-1:0] occupancy
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0] hi_r, lo_r;
  logic             thr_ok;

  assign thr_ok = init && (umbral_lo < umbral_hi) && (umbral_hi <= DEPTH_C);

  // Lanes compare against the registered thresholds, so a new pair takes effect one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= CNT_W'(DEF_HIGH);
      lo_r <= CNT_W'(DEF_LOW);
    end else if (thr_ok) begin
      hi_r <= umbral_hi;
      lo_r <= umbral_lo;
    end
  end

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_lane
    fifo_flow_lane #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .hi    (hi_r),
      .lo    (lo_r),
      .count (occupancy[i*CNT_W +: CNT_W]),
      .pause (pause[i]),
      .cont  (cont[i]),
      .err   (error_full[i]),
      .empty (empty[i])
    );
  end

  assign all_empty = &empty;
endmodule

// File: tb/tb_fifo_flow_monitor.sv
// Directed vector table for the documented scenarios, then randomized traffic
// checked against a count/threshold model built from the block's rules.

module tb_fifo_flow_monitor;
  localparam int N = 4, D = 8, W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1, init = 1'b0;
  logic [W-1:0]   umbral_hi = '0, umbral_lo = '0;
  logic [N-1:0]   push = '0, pop = '0;
  logic [N-1:0]   pause, cont, error_full, empty;
  logic           all_empty;
  logic [N*W-1:0] occupancy;

  always #5 clk = ~clk;

  fifo_flow_monitor #(.NUM_FIFOS(N), .DEPTH(D), .CNT_W(W), .DEF_HIGH(6), .DEF_LOW(2)) dut (
    .clk(clk), .rst(rst), .init(init), .umbral_hi(umbral_hi), .umbral_lo(umbral_lo),
    .push(push), .pop(pop), .pause(pause), .cont(cont), .error_full(error_full),
    .empty(empty), .all_empty(all_empty), .occupancy(occupancy)
  );

  typedef struct {
    logic         r, in;
    logic [W-1:0] hi, lo;
    logic [N-1:0] pu, po, e_pause, e_cont, e_err, e_empty;
    logic [15:0]  e_occ;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0, errors = 0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic in, logic [W-1:0] h, logic [W-1:0] l,
                       logic [N-1:0] pu, logic [N-1:0] po);
    @(negedge clk);
    rst = r; init = in; umbral_hi = h; umbral_lo = l; push = pu; pop = po;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] occ(int o3, int o2, int o1, int o0);
    return {4'(o3), 4'(o2), 4'(o1), 4'(o0)};
  endfunction

  task automatic add(logic r, logic in, int h, int l, logic [N-1:0] pu, logic [N-1:0] po,
                     logic [N-1:0] ep, logic [N-1:0] ec, logic [N-1:0] ee,
                     logic [N-1:0] em, logic [15:0] eo);
    vec_t v;
    v.r = r; v.in = in; v.hi = 4'(h); v.lo = 4'(l); v.pu = pu; v.po = po;
    v.e_pause = ep; v.e_cont = ec; v.e_err = ee; v.e_empty = em; v.e_occ = eo;
    tbl.push_back(v);
  endtask

  // reference model state
  int cnt[N];
  bit paused[N], err_m[N], p_m[N], c_m[N];
  int hi_m, lo_m;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0; paused[i] = 0; err_m[i] = 0; p_m[i] = 0; c_m[i] = 0;
    end
    hi_m = 6; lo_m = 2;
  endtask

  task automatic model_step(bit r, bit in, int h, int l, logic [N-1:0] pu, logic [N-1:0] po);
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      int take, give, nx;
      give = (po[i] && cnt[i] > 0) ? 1 : 0;
      take = (pu[i] && (cnt[i] < D || po[i])) ? 1 : 0;
      if (pu[i] && !po[i] && cnt[i] == D) err_m[i] = 1;
      nx = cnt[i] + take - give;
      p_m[i] = 0; c_m[i] = 0;
      if (!paused[i] && nx >= hi_m) begin paused[i] = 1; p_m[i] = 1; end
      else if (paused[i] && nx <= lo_m) begin paused[i] = 0; c_m[i] = 1; end
      cnt[i] = nx;
    end
    if (in && l < h && h <= D) begin hi_m = h; lo_m = l; end
  endtask

  initial begin
    // 1) reset, then fill FIFO0 to the high threshold
    add(1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'hF, occ(0, 0, 0, 0));
    for (int k = 1; k <= 6; k++)
      add(0, 0, 0, 0, 4'b0001, 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 0, 0, 4'b1110, occ(0, 0, 0, k));
    add(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1110, occ(0, 0, 0, 6));
    // 2) drain to low threshold, then refill
    for (int k = 5; k >= 2; k--)
      add(0, 0, 0, 0, 4'b0000, 4'b0001, 0, (k == 2) ? 4'b0001 : 4'b0000, 0, 4'b1110, occ(0, 0, 0, k));
    add(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 4'b1110, occ(0, 0, 0, 2));
    for (int k = 3; k <= 6; k++)
      add(0, 0, 0, 0, 4'b0001, 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 0, 0, 4'b1110, occ(0, 0, 0, k));
    // 3) overflow FIFO1; push&pop at full on FIFO2
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, 0, 4'b0010, 4'b0000, (k == 6) ? 4'b0010 : 4'b0000, 0, 0, 4'b1100, occ(0, 0, k, 6));
    add(0, 0, 0, 0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b1100, occ(0, 0, 8, 6));
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, 0, 4'b0100, 4'b0000, (k == 6) ? 4'b0100 : 4'b0000, 0, 4'b0010, 4'b1000, occ(0, k, 8, 6));
    add(0, 0, 0, 0, 4'b0100, 4'b0100, 0, 0, 4'b0010, 4'b1000, occ(0, 8, 8, 6));
    // 4) empty-FIFO corner cases on FIFO3
    add(0, 0, 0, 0, 4'b1000, 4'b1000, 0, 0, 4'b0010, 4'b0000, occ(1, 8, 8, 6));
    add(0, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, 4'b0010, 4'b1000, occ(0, 8, 8, 6));
    add(0, 0, 0, 0, 4'b0000, 4'b1000, 0, 0, 4'b0010, 4'b1000, occ(0, 8, 8, 6));
    // 5) valid write hi=4/lo=1 with concurrent push, then an illegal pair
    add(0, 1, 4, 1, 4'b1000, 4'b0000, 0, 0, 4'b0010, 4'b0000, occ(1, 8, 8, 6));
    for (int k = 2; k <= 4; k++)
      add(0, 0, 0, 0, 4'b1000, 4'b0000, (k == 4) ? 4'b1000 : 4'b0000, 0, 4'b0010, 4'b0000, occ(k, 8, 8, 6));
    add(0, 1, 2, 3, 4'b0000, 4'b1000, 0, 0, 4'b0010, 4'b0000, occ(3, 8, 8, 6));
    for (int k = 2; k >= 1; k--)
      add(0, 0, 0, 0, 4'b0000, 4'b1000, 0, (k == 1) ? 4'b1000 : 4'b0000, 4'b0010, 4'b0000, occ(k, 8, 8, 6));
    for (int k = 2; k <= 4; k++)
      add(0, 0, 0, 0, 4'b1000, 4'b0000, (k == 4) ? 4'b1000 : 4'b0000, 0, 4'b0010, 4'b0000, occ(k, 8, 8, 6));
    // 6) reset while FIFO0 paused at 7; thresholds return to 6/2
    add(0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 4'b0010, 4'b0000, occ(4, 8, 8, 7));
    add(1, 1, 3, 1, 4'b1111, 4'b0000, 0, 0, 0, 4'hF, occ(0, 0, 0, 0));
    for (int k = 1; k <= 6; k++)
      add(0, 0, 0, 0, 4'b0001, 4'b0000, (k == 6) ? 4'b0001 : 4'b0000, 0, 0, 4'b1110, occ(0, 0, 0, k));

    foreach (tbl[j]) begin
      drive(tbl[j].r, tbl[j].in, tbl[j].hi, tbl[j].lo, tbl[j].pu, tbl[j].po);
      chk($sformatf("v%0d pause", j), 16'(pause), 16'(tbl[j].e_pause));
      chk($sformatf("v%0d cont", j), 16'(cont), 16'(tbl[j].e_cont));
      chk($sformatf("v%0d error_full", j), 16'(error_full), 16'(tbl[j].e_err));
      chk($sformatf("v%0d empty", j), 16'(empty), 16'(tbl[j].e_empty));
      chk($sformatf("v%0d all_empty", j), 16'(all_empty), 16'(&tbl[j].e_empty));
      chk($sformatf("v%0d occupancy", j), occupancy, tbl[j].e_occ);
    end

    // randomized traffic against the model
    drive(1, 0, 0, 0, '0, '0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic         r, in;
      logic [W-1:0] h, l;
      logic [N-1:0] pu, po, ep, ec, ee, em;
      logic [15:0]  eo;
      int           pb;
      pb = (c < 1500) ? 62 : 40;
      r  = ($urandom_range(0, 299) == 0);
      in = ($urandom_range(0, 19) == 0);
      h  = 4'($urandom_range(0, 10));
      l  = 4'($urandom_range(0, 9));
      for (int i = 0; i < N; i++) begin
        pu[i] = ($urandom_range(0, 99) < pb);
        po[i] = ($urandom_range(0, 99) < 100 - pb);
      end
      drive(r, in, h, l, pu, po);
      model_step(r, in, int'(h), int'(l), pu, po);
      eo = '0;
      for (int i = 0; i < N; i++) begin
        ep[i] = p_m[i]; ec[i] = c_m[i]; ee[i] = err_m[i]; em[i] = (cnt[i] == 0);
        eo[i*W +: W] = 4'(cnt[i]);
      end
      chk($sformatf("r%0d pause", c), 16'(pause), 16'(ep));
      chk($sformatf("r%0d cont", c), 16'(cont), 16'(ec));
      chk($sformatf("r%0d error_full", c), 16'(error_full), 16'(ee));
      chk($sformatf("r%0d empty", c), 16'(empty), 16'(em));
      chk($sformatf("r%0d all_empty", c), 16'(all_empty), 16'(&em));
      chk($sformatf("r%0d occupancy", c), occupancy, eo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
